// File: rtl/fsm_save_ctrl.sv
// Checkpoint save controller: invalidates the commit token, copies every register word
// to non-volatile memory, then writes the token so only complete checkpoints look valid.
module fsm_save_ctrl #(
  parameter int                N_REGS      = 32,
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 8,
  parameter int                BASE_ADDR   = 0,
  parameter logic [DATA_W-1:0] VALID_TOKEN = 32'hC0DE_5AFE,
  parameter int                IDX_W       = $clog2(N_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_ack_mem,
  input  logic [DATA_W-1:0] i_reg_data,
  output logic [IDX_W-1:0]  o_reg_idx,
  output logic              o_write_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted,
  output logic [2:0]        o_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INVAL  = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ABORT  = 3'd6;

  localparam logic [ADDR_W-1:0] TOKEN_ADDR = ADDR_W'(BASE_ADDR + N_REGS);
  localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE_ADDR);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_REGS - 1);

  // Handshake: a write is offered while o_write_en=1 with address/data held constant;
  // it is consumed at the rising edge where i_ack_mem=1, and o_write_en drops (or the
  // next write is presented) in the following cycle. i_ack_mem is ignored otherwise.

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [IDX_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start && !i_abort) w_next = S_INVAL;
      S_INVAL:  if (i_abort) w_next = S_ABORT;
                else if (i_ack_mem) w_next = S_FETCH;
      S_FETCH:  w_next = i_abort ? S_ABORT : S_WRITE;
      S_WRITE:  if (i_abort) w_next = S_ABORT;
                else if (i_ack_mem) w_next = (r_cnt == LAST_IDX) ? S_COMMIT : S_FETCH;
      // Once the token write is acknowledged the checkpoint is committed, abort or not.
      S_COMMIT: if (i_ack_mem) w_next = S_DONE;
                else if (i_abort) w_next = S_ABORT;
      S_DONE:   w_next = S_IDLE;
      S_ABORT:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_INVAL) begin
            r_cnt   <= '0;
            r_addr  <= TOKEN_ADDR;
            r_wdata <= '0;
          end
        end
        S_FETCH: begin
          r_addr  <= BASE_A + ADDR_W'(r_cnt);
          r_wdata <= i_reg_data;
        end
        S_WRITE: begin
          if (w_next == S_FETCH) begin
            r_cnt <= r_cnt + IDX_W'(1);
          end else if (w_next == S_COMMIT) begin
            r_addr  <= TOKEN_ADDR;
            r_wdata <= VALID_TOKEN;
          end
        end
        default: ;
      endcase
    end
  end

  // The token slot must not wrap onto the register area.
  always_ff @(posedge i_clk) begin
    assert (64'(BASE_ADDR) + 64'(N_REGS) < (64'd1 << ADDR_W))
      else $error("token address exceeds address space");
  end

  assign o_reg_idx   = r_cnt;
  assign o_write_en  = (r_state == S_INVAL) || (r_state == S_WRITE) || (r_state == S_COMMIT);
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_aborted   = (r_state == S_ABORT);
  assign o_state     = r_state;

endmodule

// File: tb/tb_fsm_save_ctrl.sv
// Bench for fsm_save_ctrl: a memory-side monitor records accepted writes and they are
// compared against the write list a complete or interrupted save must produce.
module tb_fsm_save_ctrl;

  localparam int          N      = 32;
  localparam int          DW     = 32;
  localparam int          AW     = 8;
  localparam int          W      = AW + DW;
  localparam logic [31:0] TOKEN  = 32'hC0DE_5AFE;
  localparam logic [7:0]  TOK_A  = 8'(N);

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          i_ack_mem;
  logic [DW-1:0] i_reg_data;
  logic [4:0]    o_reg_idx;
  logic          o_write_en;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_busy;
  logic          o_done;
  logic          o_aborted;
  logic [2:0]    o_state;

  fsm_save_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_ack_mem(i_ack_mem), .i_reg_data(i_reg_data), .o_reg_idx(o_reg_idx),
    .o_write_en(o_write_en), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_state(o_state)
  );

  // clock / register file
  always #5 i_clk = ~i_clk;

  logic [DW-1:0] regs [N];
  assign i_reg_data = regs[o_reg_idx];

  // memory side: 0 manual, 1 always ack, 2 ack in 4th cycle of each write, 3 random
  int   ack_mode = 1;
  logic ack_manual = 1'b0;
  int   wcnt = 0;
  logic rnd = 1'b0;
  assign i_ack_mem = (ack_mode == 1) ||
                     (ack_mode == 2 && o_write_en && wcnt >= 4) ||
                     (ack_mode == 3 && o_write_en && rnd) ||
                     (ack_mode == 0 && ack_manual);

  logic [W-1:0]  got_q[$];
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] mem [256];
  int done_cnt = 0, abort_cnt = 0, stall_bad = 0, stall_seen = 0;

  initial begin
    logic         pend, prev_we, prev_acc;
    logic [W-1:0] prev_aw;
    prev_we = 1'b0; prev_acc = 1'b0; prev_aw = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(negedge i_clk); #1;
      pend = o_write_en && i_ack_mem;
      if (!i_rst) begin
        if (pend) begin
          got_q.push_back({o_mem_addr, o_mem_wdata});
          mem[o_mem_addr] = o_mem_wdata;
        end
        if (o_done) done_cnt++;
        if (o_aborted) abort_cnt++;
        if (o_write_en && prev_we && !prev_acc) begin
          stall_seen++;
          if ({o_mem_addr, o_mem_wdata} != prev_aw) stall_bad++;
        end
      end
      prev_we = o_write_en; prev_acc = pend; prev_aw = {o_mem_addr, o_mem_wdata};
      @(posedge i_clk); #1;
      if (!o_write_en) wcnt = 0;
      else if (pend) wcnt = 1;
      else wcnt++;
      rnd = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input int n_regs, input bit commit);
    exp_q.delete();
    exp_q.push_back({TOK_A, 32'h0});
    for (int i = 0; i < n_regs; i++) exp_q.push_back({8'(i), regs[i]});
    if (commit) exp_q.push_back({TOK_A, TOKEN});
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  // driver tasks
  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic start_pulse();
    i_start = 1'b1; step(); i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!o_done && cyc < budget) begin step(); cyc++; end
    if (!o_done) check("done_timeout", 0, 1);
  endtask

  task automatic ack_writes(input int n);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!o_write_en && t < 50) begin step(); t++; end
      if (t == 50) check("ack_wait_timeout", 0, 1);
      ack_manual = 1'b1; step(); ack_manual = 1'b0;
    end
  endtask

  task automatic rand_regs();
    for (int i = 0; i < N; i++) regs[i] = $urandom;
  endtask

  initial begin
    int cyc, d0, a0, t;
    for (int i = 0; i < N; i++) regs[i] = 32'h100 + 32'(i);
    step(); step();
    check("rst_busy", o_busy, 0);
    check("rst_we", o_write_en, 0);
    check("rst_done", o_done, 0);
    check("rst_aborted", o_aborted, 0);
    check("rst_idx", o_reg_idx, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_wdata", o_mem_wdata, 0);
    i_rst = 1'b0;
    step();

    // zero-wait save
    ack_mode = 1; got_q.delete();
    start_pulse();
    wait_done(500, cyc);
    check("t1_done_cycle", cyc, 2 * N + 3);
    build_exp(N, 1); compare_writes("t1");
    check("t1_token", mem[TOK_A], TOKEN);
    step();
    check("t1_done_pulse", o_done, 0);
    check("t1_idle", o_busy, 0);

    // 3 wait cycles on every write
    rand_regs(); ack_mode = 2; got_q.delete();
    start_pulse();
    wait_done(1000, cyc);
    check("t2_done_cycle", cyc, 2 * N + 3 + 3 * (N + 2));
    build_exp(N, 1); compare_writes("t2");
    check("t2_stall_stable", stall_bad, 0);
    check("t2_stall_seen", stall_seen >= 3 * (N + 2), 1);
    step();

    // abort in WRITE of reg 10 without ack
    rand_regs(); ack_mode = 0; got_q.delete(); d0 = done_cnt;
    start_pulse();
    ack_writes(11);
    t = 0;
    while (!o_write_en && t < 20) begin step(); t++; end
    check("t3_idx", o_reg_idx, 10);
    check("t3_addr", o_mem_addr, 10);
    i_abort = 1'b1; step(); i_abort = 1'b0;
    check("t3_aborted", o_aborted, 1);
    check("t3_we", o_write_en, 0);
    step();
    check("t3_aborted_pulse", o_aborted, 0);
    check("t3_busy", o_busy, 0);
    build_exp(10, 0); compare_writes("t3");
    check("t3_token_invalid", mem[TOK_A], 0);
    check("t3_no_done", done_cnt, d0);

    // COMMIT with ack and abort together
    rand_regs(); ack_mode = 1; got_q.delete();
    start_pulse();
    t = 0;
    while (!(o_write_en && o_mem_addr == TOK_A && o_mem_wdata == TOKEN) && t < 200) begin
      step(); t++;
    end
    i_abort = 1'b1; step(); i_abort = 1'b0;
    check("t4a_done", o_done, 1);
    check("t4a_aborted", o_aborted, 0);
    build_exp(N, 1); compare_writes("t4a");
    step();

    // abort alone in COMMIT
    rand_regs(); ack_mode = 0; got_q.delete(); d0 = done_cnt;
    start_pulse();
    ack_writes(N + 1);
    t = 0;
    while (!o_write_en && t < 20) begin step(); t++; end
    check("t4b_token_offer", o_mem_wdata, TOKEN);
    i_abort = 1'b1; step(); i_abort = 1'b0;
    check("t4b_aborted", o_aborted, 1);
    check("t4b_done", o_done, 0);
    build_exp(N, 0); compare_writes("t4b");
    check("t4b_token_invalid", mem[TOK_A], 0);
    step();
    check("t4b_no_done", done_cnt, d0);

    // Start+Abort in IDLE ignored; Start while busy ignored
    rand_regs(); ack_mode = 1; got_q.delete(); d0 = done_cnt;
    i_start = 1'b1; i_abort = 1'b1; step(); i_start = 1'b0; i_abort = 1'b0;
    check("t5_start_abort_idle", o_busy, 0);
    start_pulse();
    for (int k = 0; k < 100; k++) begin
      i_start = o_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    i_start = 1'b0;
    check("t5_one_done", done_cnt - d0, 1);
    check("t5_idle", o_busy, 0);
    build_exp(N, 1); compare_writes("t5");

    // async reset during FETCH of reg 5
    rand_regs(); ack_mode = 1; d0 = done_cnt; a0 = abort_cnt;
    start_pulse();
    t = 0;
    while (!(o_busy && !o_write_en && o_reg_idx == 5) && t < 100) begin step(); t++; end
    #2 i_rst = 1'b1;
    #1;
    check("t6_busy", o_busy, 0);
    check("t6_we", o_write_en, 0);
    check("t6_idx", o_reg_idx, 0);
    check("t6_addr", o_mem_addr, 0);
    check("t6_wdata", o_mem_wdata, 0);
    check("t6_done", o_done, 0);
    check("t6_aborted", o_aborted, 0);
    step(); i_rst = 1'b0; step();
    check("t6_no_pulses", (done_cnt - d0) + (abort_cnt - a0), 0);
    rand_regs(); got_q.delete();
    start_pulse();
    wait_done(500, cyc);
    check("t6_restart_cycle", cyc, 2 * N + 3);
    build_exp(N, 1); compare_writes("t6");
    step();

    // random ack timing, several saves
    ack_mode = 3;
    for (int r = 0; r < 3; r++) begin
      rand_regs(); got_q.delete();
      start_pulse();
      wait_done(2000, cyc);
      build_exp(N, 1); compare_writes($sformatf("t7_%0d", r));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
